// File: rtl/adpll_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adpll_pkg
// Purpose  : Shared widths, default loop-filter gains and the FSM state type
//            for the ADPLL digital loop filter.
// Revision : 1.0 - initial release
// ============================================================================
package adpll_pkg;

    localparam int TDC_W = 32;    // thermometer code width from the TDC
    localparam int ERR_W = 7;     // signed phase error, -32..+32
    localparam int CNT_W = 6;     // popcount width, 0..32

    localparam int DEF_CW       = 10;
    localparam int DEF_CENTER   = 512;
    localparam int DEF_KP_SHIFT = 2;
    localparam int DEF_KI_SHIFT = 3;
    localparam int DEF_IW       = 14;
    localparam int DEF_LOCK_TOL = 1;
    localparam int DEF_LOCK_CNT = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        DECODE = 3'd2,
        FILTER = 3'd3,
        OUTPUT = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/therm_popcount.sv
`default_nettype none
// ============================================================================
// Module   : therm_popcount
// Purpose  : Counts the ones in a TDC code. Works on any bit pattern, so a
//            bubbled thermometer code still yields a usable magnitude.
// Revision : 1.0 - initial release
// ============================================================================
module therm_popcount
    import adpll_pkg::*;
(
    input  logic [TDC_W-1:0] code_i,
    output logic [CNT_W-1:0] count_o
);

    // Plain ones-count over the whole code
    always_comb begin
        count_o = '0;
        for (int i = 0; i < TDC_W; i++) begin
            count_o = count_o + {{(CNT_W-1){1'b0}}, code_i[i]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/adpll_loop_filter.sv
`default_nettype none
// ============================================================================
// Module   : adpll_loop_filter
// Purpose  : Detects the end of each TDC phase measurement, decodes the
//            UP/DWN thermometer codes to a signed error and runs a saturating
//            PI filter producing the DCO control word and a lock flag.
// Revision : 1.0 - initial release
// ============================================================================
module adpll_loop_filter
    import adpll_pkg::*;
#(
    parameter int CW       = DEF_CW,
    parameter int CENTER   = DEF_CENTER,
    parameter int KP_SHIFT = DEF_KP_SHIFT,
    parameter int KI_SHIFT = DEF_KI_SHIFT,
    parameter int IW       = DEF_IW,
    parameter int LOCK_TOL = DEF_LOCK_TOL,
    parameter int LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [TDC_W-1:0]        up_error,
    input  logic [TDC_W-1:0]        dwn_error,
    output logic [CW-1:0]           dco_ctrl,
    output logic                    ctrl_valid,
    output logic signed [ERR_W-1:0] phase_err,
    output logic                    locked,
    output logic                    meas_drop
);

    // Sum width leaves headroom over the integrator for P term and centre
    localparam int SW  = IW + 3;
    localparam int LCW = $clog2(LOCK_CNT + 1);

    localparam logic signed [IW:0]      c_INTEG_MAX = (IW+1)'((2**(IW-1)) - 1);
    localparam logic signed [IW:0]      c_INTEG_MIN = (IW+1)'(-(2**(IW-1)));
    localparam logic signed [SW-1:0]    c_DCO_MAX   = SW'((2**CW) - 1);
    localparam logic signed [SW-1:0]    c_CENTER    = SW'(CENTER);
    localparam logic signed [ERR_W-1:0] c_TOL_POS   = ERR_W'(LOCK_TOL);
    localparam logic signed [ERR_W-1:0] c_TOL_NEG   = ERR_W'(-LOCK_TOL);
    localparam logic [LCW-1:0]          c_LOCK_FULL = LCW'(LOCK_CNT);

    state_t                   state_q;
    logic [TDC_W-1:0]         prev_up_q, prev_dwn_q;
    logic [TDC_W-1:0]         lat_up_q, lat_dwn_q;
    logic                     discard_q;
    logic signed [ERR_W-1:0]  phase_err_q;
    logic signed [IW-1:0]     integ_q;
    logic [CW-1:0]            dco_ctrl_q;
    logic                     ctrl_valid_q, meas_drop_q, locked_q;
    logic [LCW-1:0]           lock_cnt_q;

    logic [CNT_W-1:0]         cnt_up_w, cnt_dwn_w;
    logic signed [ERR_W-1:0]  err_d;
    logic                     inputs_nz_w, meas_end_w, in_window_w;
    logic signed [IW:0]       integ_sum_w;
    logic signed [IW-1:0]     integ_d;
    logic signed [SW-1:0]     err_ext_w, integ_ext_w, sum_w;
    logic [CW-1:0]            dco_ctrl_d;
    logic [LCW-1:0]           lock_cnt_d;

    therm_popcount u_pop_up  (.code_i(lat_up_q),  .count_o(cnt_up_w));
    therm_popcount u_pop_dwn (.code_i(lat_dwn_q), .count_o(cnt_dwn_w));

    // Measurement framing and error decode
    always_comb begin
        inputs_nz_w = (up_error != '0) || (dwn_error != '0);
        meas_end_w  = !inputs_nz_w && ((prev_up_q | prev_dwn_q) != '0);
        err_d       = $signed({1'b0, cnt_up_w}) - $signed({1'b0, cnt_dwn_w});
    end

    // PI datapath: saturating integrator, then clamped control word
    always_comb begin
        integ_sum_w = {integ_q[IW-1], integ_q}
                    + {{(IW+1-ERR_W){phase_err_q[ERR_W-1]}}, phase_err_q};
        if (integ_sum_w > c_INTEG_MAX) begin
            integ_d = c_INTEG_MAX[IW-1:0];
        end else if (integ_sum_w < c_INTEG_MIN) begin
            integ_d = c_INTEG_MIN[IW-1:0];
        end else begin
            integ_d = integ_sum_w[IW-1:0];
        end
        err_ext_w   = {{(SW-ERR_W){phase_err_q[ERR_W-1]}}, phase_err_q};
        integ_ext_w = {{(SW-IW){integ_d[IW-1]}}, integ_d};
        sum_w       = c_CENTER + (err_ext_w <<< KP_SHIFT) + (integ_ext_w >>> KI_SHIFT);
        if (sum_w < 0) begin
            dco_ctrl_d = '0;
        end else if (sum_w > c_DCO_MAX) begin
            dco_ctrl_d = c_DCO_MAX[CW-1:0];
        end else begin
            dco_ctrl_d = sum_w[CW-1:0];
        end
    end

    // Lock counter next value: saturating run length of in-window errors
    always_comb begin
        in_window_w = (phase_err_q <= c_TOL_POS) && (phase_err_q >= c_TOL_NEG);
        if (!in_window_w) begin
            lock_cnt_d = '0;
        end else if (lock_cnt_q == c_LOCK_FULL) begin
            lock_cnt_d = lock_cnt_q;
        end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            prev_up_q    <= '0;
            prev_dwn_q   <= '0;
            lat_up_q     <= '0;
            lat_dwn_q    <= '0;
            discard_q    <= 1'b0;
            phase_err_q  <= '0;
            integ_q      <= '0;
            dco_ctrl_q   <= CW'(CENTER);
            ctrl_valid_q <= 1'b0;
            meas_drop_q  <= 1'b0;
            locked_q     <= 1'b0;
            lock_cnt_q   <= '0;
        end else begin
            ctrl_valid_q <= 1'b0;
            meas_drop_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    prev_up_q  <= up_error;
                    prev_dwn_q <= dwn_error;
                    if (en) begin
                        state_q   <= ARMED;
                        discard_q <= inputs_nz_w;
                    end
                end
                ARMED: begin
                    prev_up_q  <= up_error;
                    prev_dwn_q <= dwn_error;
                    if (!en) begin
                        state_q <= IDLE;
                    end else if (meas_end_w) begin
                        if (discard_q) begin
                            meas_drop_q <= 1'b1;
                            discard_q   <= 1'b0;
                        end else begin
                            lat_up_q   <= prev_up_q;
                            lat_dwn_q  <= prev_dwn_q;
                            state_q    <= DECODE;
                        end
                    end
                end
                DECODE: begin
                    phase_err_q <= err_d;
                    state_q     <= FILTER;
                end
                FILTER: begin
                    // Results become visible together in the OUTPUT cycle
                    integ_q      <= integ_d;
                    dco_ctrl_q   <= dco_ctrl_d;
                    ctrl_valid_q <= 1'b1;
                    lock_cnt_q   <= lock_cnt_d;
                    locked_q     <= (lock_cnt_d == c_LOCK_FULL);
                    state_q      <= OUTPUT;
                end
                OUTPUT: begin
                    // A code already active here was partially missed
                    prev_up_q  <= up_error;
                    prev_dwn_q <= dwn_error;
                    discard_q  <= inputs_nz_w;
                    state_q    <= en ? ARMED : IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dco_ctrl   = dco_ctrl_q;
    assign ctrl_valid = ctrl_valid_q;
    assign phase_err  = phase_err_q;
    assign locked     = locked_q;
    assign meas_drop  = meas_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_adpll_loop_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_adpll_loop_filter
// Purpose  : Scoreboard bench for the ADPLL loop filter with a behavioural
//            PI reference model and randomized TDC measurements.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adpll_loop_filter;

    localparam int CW       = 10;
    localparam int CENTER   = 512;
    localparam int KP_SHIFT = 2;
    localparam int KI_SHIFT = 3;
    localparam int IW       = 14;
    localparam int LOCK_TOL = 1;
    localparam int LOCK_CNT = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              en = 1'b0;
    logic [31:0]       up_error = '0;
    logic [31:0]       dwn_error = '0;
    logic [CW-1:0]     dco_ctrl;
    logic              ctrl_valid;
    logic signed [6:0] phase_err;
    logic              locked;
    logic              meas_drop;

    adpll_loop_filter #(
        .CW(CW), .CENTER(CENTER), .KP_SHIFT(KP_SHIFT), .KI_SHIFT(KI_SHIFT),
        .IW(IW), .LOCK_TOL(LOCK_TOL), .LOCK_CNT(LOCK_CNT)
    ) dut (
        .clk(clk), .reset(reset), .en(en),
        .up_error(up_error), .dwn_error(dwn_error),
        .dco_ctrl(dco_ctrl), .ctrl_valid(ctrl_valid), .phase_err(phase_err),
        .locked(locked), .meas_drop(meas_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int dco;
        int perr;
        int lck;
        int cyc;
    } exp_t;

    exp_t sb_q[$];
    int   drop_q[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model state
    int m_integ = 0;
    int m_cnt   = 0;
    int m_dco   = CENTER;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int floor_div(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic logic [31:0] therm(input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    // One measurement through an ideal PI filter with clamping and lock run
    task automatic model_step(input logic [31:0] u, input logic [31:0] d, output exp_t e);
        int err, s;
        err = $countones(u) - $countones(d);
        m_integ = m_integ + err;
        if (m_integ >  (2**(IW-1)) - 1) m_integ = (2**(IW-1)) - 1;
        if (m_integ < -(2**(IW-1)))     m_integ = -(2**(IW-1));
        s = CENTER + err * (2**KP_SHIFT) + floor_div(m_integ, 2**KI_SHIFT);
        if (s < 0) s = 0;
        if (s > (2**CW) - 1) s = (2**CW) - 1;
        if (err <= LOCK_TOL && err >= -LOCK_TOL) m_cnt = (m_cnt < LOCK_CNT) ? m_cnt + 1 : LOCK_CNT;
        else m_cnt = 0;
        m_dco  = s;
        e.dco  = s;
        e.perr = err;
        e.lck  = (m_cnt == LOCK_CNT) ? 1 : 0;
        e.cyc  = 0;
    endtask

    task automatic drive(input logic [31:0] u, input logic [31:0] d);
        @(posedge clk); #1;
        up_error  = u;
        dwn_error = d;
    endtask

    // Final active cycle, zero-detect cycle, then let the pipeline drain
    task automatic end_meas(input logic [31:0] u, input logic [31:0] d);
        exp_t e;
        drive(u, d);
        drive('0, '0);
        model_step(u, d, e);
        e.cyc = cyc + 3;
        sb_q.push_back(e);
        repeat (3) drive('0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        up_error = '0;
        dwn_error = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_integ = 0;
        m_cnt   = 0;
        m_dco   = CENTER;
        @(posedge clk); #1;
    endtask

    // Monitor: pop expectations whenever the DUT presents a result
    always @(negedge clk) begin
        exp_t e;
        int   dc;
        if (ctrl_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_valid: got ctrl_valid=1 expected none (t=%0t)", $time);
            end else begin
                e = sb_q.pop_front();
                check("valid_cycle", cyc, e.cyc);
                check("dco_ctrl", dco_ctrl, e.dco);
                check("phase_err", phase_err, e.perr);
                check("locked", locked, e.lck);
            end
        end
        if (meas_drop) begin
            if (drop_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_drop: got meas_drop=1 expected none (t=%0t)", $time);
            end else begin
                dc = drop_q.pop_front();
                check("drop_cycle", cyc, dc);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] u, d;
        int ku, kd, len;

        // Reset state
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dco", dco_ctrl, CENTER);
        check("rst_valid", ctrl_valid, 0);
        check("rst_drop", meas_drop, 0);
        check("rst_perr", phase_err, 0);
        check("rst_locked", locked, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Case 1: UP ramp to five ones
        drive(32'h1, 0); drive(32'h3, 0); drive(32'h7, 0); drive(32'hF, 0);
        end_meas(32'h1F, 0);
        check("c1_dco", dco_ctrl, 532);
        check("c1_perr", phase_err, 5);

        // Case 2: mixed UP/DWN from reset
        do_reset();
        drive(32'h1, 32'h1); drive(32'h1, 32'h3);
        end_meas(32'h1, 32'h7);
        check("c2_dco", dco_ctrl, 503);

        // Case 4: lock after eight in-window measurements, loss on a big error
        do_reset();
        for (int i = 0; i < LOCK_CNT; i++) begin
            ku = $urandom_range(0, 30);
            kd = ku + $urandom_range(0, 2) - 1;
            if (kd < 0) kd = 0;
            if (ku == 0 && kd == 0) ku = 1;
            end_meas(therm(ku), therm(kd));
            if (i == LOCK_CNT - 2) check("c4_not_yet", locked, 0);
        end
        check("c4_locked", locked, 1);
        end_meas(therm(5), therm(2));
        check("c4_unlock", locked, 0);
        for (int i = 0; i < LOCK_CNT; i++) end_meas(therm(4), therm(4));
        check("c4_relock", locked, 1);

        // Case 5: reset while in FILTER loses the in-flight result
        drive(therm(20), 0);
        drive('0, '0);          // zero-detect
        drive('0, '0);          // DECODE
        @(posedge clk); #1;     // FILTER
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_integ = 0; m_cnt = 0; m_dco = CENTER;
        check("c5_dco", dco_ctrl, CENTER);
        check("c5_valid", ctrl_valid, 0);
        check("c5_locked", locked, 0);
        check("c5_perr", phase_err, 0);
        repeat (6) drive('0, '0);
        end_meas(therm(3), therm(1));

        // Case 6: enable raised mid-measurement, dropped then clean update
        en = 1'b0;
        repeat (2) drive('0, '0);
        drive(32'h3, 0);
        @(posedge clk); #1;
        en = 1'b1;
        drive('0, '0);
        drop_q.push_back(cyc + 1);
        repeat (4) drive('0, '0);
        check("c6_dco_hold", dco_ctrl, m_dco);
        end_meas(therm(2), therm(6));

        // Case 3: clamp high then clamp low, no wrap
        for (int i = 0; i < 300; i++) end_meas(32'hFFFF_FFFF, 0);
        check("c3_clamp_hi", dco_ctrl, 1023);
        for (int i = 0; i < 400; i++) end_meas(0, 32'hFFFF_FFFF);
        check("c3_clamp_lo", dco_ctrl, 0);
        end_meas(32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Randomized measurements, mixing thermometer and raw codes
        do_reset();
        for (int n = 0; n < 200; n++) begin
            len = $urandom_range(1, 4);
            for (int k = 1; k < len; k++) drive(therm($urandom_range(1, 32)), therm($urandom_range(0, 32)));
            if ($urandom_range(0, 3) == 0) begin
                u = $urandom;
                d = $urandom;
            end else begin
                ku = $urandom_range(0, 32);
                kd = ($urandom_range(0, 1) == 1) ? ku + $urandom_range(0, 2) - 1 : $urandom_range(0, 32);
                if (kd < 0) kd = 0;
                if (kd > 32) kd = 32;
                u = therm(ku);
                d = therm(kd);
            end
            if ((u | d) == 32'h0) u = 32'h1;
            end_meas(u, d);
        end

        repeat (10) drive('0, '0);
        check("sb_drain", sb_q.size(), 0);
        check("drop_drain", drop_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
